writeback_queue: RTL and testbench

Write-side initiator for the 8x16 processor register file. It buffers register write-back requests from execute and load sources in a small in-order FIFO and drains one entry per cycle onto the register file write port. Two lookup ports forward the youngest pending value for an address, so decode sees results not yet committed to the array. It sits between the write-back mux and the register file write port.

---
 rtl/writeback_queue.sv | 109 ++++++++++
 tb/tb_writeback_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// In-order write-back buffer feeding the register file write port,
// with two youngest-match forwarding probes for decode.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_dest,
  input  logic [DW-1:0]              wb_data,
  output logic                       wb_ready,
  input  logic                       rf_hold,
  output logic                       reg_write_en,
  output logic [AW-1:0]              reg_write_dest,
  output logic [DW-1:0]              reg_write_data,
  input  logic [AW-1:0]              lookup_addr_1,
  output logic                       lookup_hit_1,
  output logic [DW-1:0]              lookup_data_1,
  input  logic [AW-1:0]              lookup_addr_2,
  output logic                       lookup_hit_2,
  output logic [DW-1:0]              lookup_data_2,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] dest_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          vld_q  [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wb_ready = !full;
  assign pending  = count;

  // r0 writes complete the handshake but are never stored
  assign push = wb_valid && wb_ready && (wb_dest != '0);
  assign pop  = reg_write_en;

  assign reg_write_en   = !empty && !rf_hold;
  assign reg_write_dest = empty ? '0 : dest_q[rd_ptr];
  assign reg_write_data = empty ? '0 : data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld_q[wr_ptr]  <= 1'b1;
        dest_q[wr_ptr] <= wb_dest;
        data_q[wr_ptr] <= wb_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest from the head so the last match wins
  logic [PW-1:0] idx;

  always_comb begin
    lookup_hit_1  = 1'b0;
    lookup_data_1 = '0;
    lookup_hit_2  = 1'b0;
    lookup_data_2 = '0;
    idx           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (vld_q[idx] && lookup_addr_1 != '0 &&
          dest_q[idx] == lookup_addr_1) begin
        lookup_hit_1  = 1'b1;
        lookup_data_1 = data_q[idx];
      end
      if (vld_q[idx] && lookup_addr_2 != '0 &&
          dest_q[idx] == lookup_addr_2) begin
        lookup_hit_2  = 1'b1;
        lookup_data_2 = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: queue-level reference model,
// directed scenarios followed by randomized traffic.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 16;

  typedef struct packed {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          rf_hold;
  logic          reg_write_en;
  logic [AW-1:0] reg_write_dest;
  logic [DW-1:0] reg_write_data;
  logic [AW-1:0] lookup_addr_1;
  logic          lookup_hit_1;
  logic [DW-1:0] lookup_data_1;
  logic [AW-1:0] lookup_addr_2;
  logic          lookup_hit_2;
  logic [DW-1:0] lookup_data_2;
  logic [2:0]    pending;

  writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .wb_ready       (wb_ready),
    .rf_hold        (rf_hold),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .lookup_addr_1  (lookup_addr_1),
    .lookup_hit_1   (lookup_hit_1),
    .lookup_data_1  (lookup_data_1),
    .lookup_addr_2  (lookup_addr_2),
    .lookup_hit_2   (lookup_hit_2),
    .lookup_data_2  (lookup_data_2),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;
  ent_t model_q[$];
  ent_t exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_lookup(input logic [AW-1:0] a,
                                      output bit hit);
    ent_t r;
    r   = '0;
    hit = 1'b0;
    if (a != '0)
      for (int i = 0; i < model_q.size(); i++)
        if (model_q[i].d == a) begin
          hit = 1'b1;
          r   = model_q[i];
        end
    return r;
  endfunction

  // Monitor: compares outputs against the model and pops the scoreboard
  int   mon_n;
  bit   mon_hit;
  ent_t mon_e;
  ent_t mon_w;

  always @(negedge clk) begin
    if (!done) begin
      mon_n = model_q.size();
      chk("pending", 32'(pending), 32'(mon_n));
      chk("wb_ready", 32'(wb_ready), 32'(mon_n < DEPTH));
      chk("write_en", 32'(reg_write_en),
          32'(rst && mon_n > 0 && !rf_hold));
      if (reg_write_en) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_write: dest %0d data %0h",
                   reg_write_dest, reg_write_data);
        end else begin
          mon_w = exp_q.pop_front();
          chk("write_dest", 32'(reg_write_dest), 32'(mon_w.d));
          chk("write_data", 32'(reg_write_data), 32'(mon_w.v));
        end
      end else if (mon_n == 0) begin
        chk("idle_dest", 32'(reg_write_dest), 32'd0);
        chk("idle_data", 32'(reg_write_data), 32'd0);
      end
      mon_e = ref_lookup(lookup_addr_1, mon_hit);
      chk("hit_1", 32'(lookup_hit_1), 32'(mon_hit));
      chk("data_1", 32'(lookup_data_1), 32'(mon_e.v));
      mon_e = ref_lookup(lookup_addr_2, mon_hit);
      chk("hit_2", 32'(lookup_hit_2), 32'(mon_hit));
      chk("data_2", 32'(lookup_data_2), 32'(mon_e.v));
    end
  end

  // Model update on a rising edge from the inputs held across it
  task automatic model_edge();
    int n;
    n = model_q.size();
    if (n > 0 && !rf_hold) void'(model_q.pop_front());
    if (wb_valid && n < DEPTH && wb_dest != '0) begin
      model_q.push_back({wb_dest, wb_data});
      exp_q.push_back({wb_dest, wb_data});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] d,
                       input logic [DW-1:0] x, input logic h);
    wb_valid = v;
    wb_dest  = d;
    wb_data  = x;
    rf_hold  = h;
  endtask

  initial begin
    rst           = 1'b0;
    lookup_addr_1 = 3'd3;
    lookup_addr_2 = 3'd0;
    drive(1'b1, 3'd3, 16'h5555, 1'b0);
    cyc();
    cyc();

    // Reset release, single push, write one cycle later
    rst = 1'b1;
    drive(1'b1, 3'd3, 16'h1234, 1'b0);
    cyc();
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    cyc();
    cyc();

    // Fill under hold, reject fifth, then drain in order
    lookup_addr_1 = 3'd2;
    lookup_addr_2 = 3'd4;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'(i), 16'(i), 1'b1);
      cyc();
    end
    drive(1'b1, 3'd5, 16'h0005, 1'b1);
    cyc();
    chk("fifth_rejected", 32'(pending), 32'd4);
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc();

    // Same-register forwarding priority
    lookup_addr_1 = 3'd5;
    drive(1'b1, 3'd5, 16'hAAAA, 1'b1);
    cyc();
    drive(1'b1, 3'd5, 16'hBBBB, 1'b1);
    cyc();
    drive(1'b0, 3'd0, 16'h0, 1'b1);
    cyc();
    chk("fwd_youngest", 32'(lookup_data_1), 32'hBBBB);
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    cyc();
    chk("fwd_after_one", 32'(lookup_data_1), 32'hBBBB);
    cyc();
    chk("fwd_after_all", 32'(lookup_hit_1), 32'd0);

    // r0 drop
    lookup_addr_1 = 3'd0;
    drive(1'b1, 3'd0, 16'hFFFF, 1'b0);
    cyc();
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    cyc();

    // Back-to-back pushes with continuous drain across wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'((i % 7) + 1), 16'(16'h0100 + i), 1'b0);
      lookup_addr_1 = 3'((i % 7) + 1);
      lookup_addr_2 = 3'(((i + 6) % 7) + 1);
      cyc();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    cyc();
    cyc();

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i + 1), 16'(16'hC000 + i), 1'b1);
      cyc();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    #1;
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    #1;
    chk("midrst_en", 32'(reg_write_en), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)),
            16'($urandom), ($urandom_range(3, 0) == 0));
      lookup_addr_1 = 3'($urandom_range(7, 0));
      lookup_addr_2 = 3'($urandom_range(7, 0));
      cyc();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cyc();

    done = 1'b1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
